mac_slot_sched_n: RTL and testbench

//  Parametrised tag-side slotted MAC scheduler, the N-slot successor of the fixed 8-slot tag MAC.

---
 rtl/mac_slot_sched_n_if.sv | 38 +++
 rtl/mac_slot_sched_n.sv | 298 +++++++++++++++++++++++++++++
 tb/tb_mac_slot_sched_n.sv | 263 ++++++++++++++++++++++++++
 3 files changed

// File: rtl/mac_slot_sched_n_if.sv
// Purpose : command/status bundle between the reader-side decoder and the slotted tag MAC.
// Latency : pure wiring, no storage.
// Backpressure: none; every signal is level-sampled on MAC ticks by the scheduler.
// Ports (slave = scheduler side):
//   in  ord, ctg, cur_flag, cur_rand, cur_scheme, data_size_in
//   out sending, head, datacmd, working, no_slot, slot_sel
interface mac_slot_sched_n_if #(
    parameter int N_SLOTS = 8,
    parameter int LEN_W   = 6,
    parameter int RAND_W  = 24,
    parameter int SIZE_W  = 16
);
    localparam int SEL_W = (N_SLOTS > 1) ? $clog2(N_SLOTS) : 1;

    logic [1:0]               ord;
    logic [1:0]               ctg;
    logic [N_SLOTS-1:0]       cur_flag;
    logic [RAND_W-1:0]        cur_rand;
    logic [N_SLOTS*LEN_W-1:0] cur_scheme;
    logic [SIZE_W-1:0]        data_size_in;

    logic                     sending;
    logic                     head;
    logic                     datacmd;
    logic                     working;
    logic                     no_slot;
    logic [SEL_W-1:0]         slot_sel;

    modport master (
        output ord, ctg, cur_flag, cur_rand, cur_scheme, data_size_in,
        input  sending, head, datacmd, working, no_slot, slot_sel
    );

    modport slave (
        input  ord, ctg, cur_flag, cur_rand, cur_scheme, data_size_in,
        output sending, head, datacmd, working, no_slot, slot_sel
    );
endinterface

// File: rtl/mac_slot_sched_n.sv
// Purpose : tag-side N-slot MAC scheduler: decodes beacon/scheme/heartbeat, picks a random
//           free slot and sequences header/data strobes for the backscatter modulator.
// Latency : everything advances once per MAC tick (CLK_DIV clocks); outputs are registered.
// Backpressure: none; commands are taken on an ord change while idle, ignored while busy.
// Ports:
//   clock, reset (async, active low)
//   bus.slave : ord/ctg command, cur_flag/cur_rand/cur_scheme/data_size_in context,
//               sending/head/datacmd strobes, working/no_slot/slot_sel status
module mac_slot_sched_n #(
    parameter int              N_SLOTS  = 8,
    parameter int              LEN_W    = 6,
    parameter int              ADDR_W   = 3,
    parameter logic [ADDR_W-1:0] MAC_ADDR = '0,
    parameter int              SIZE_W   = 16,
    parameter int              RAND_W   = 24,
    parameter int              CLK_DIV  = 50,
    parameter int              BCN_SLOT = 20,
    parameter int              BCN_WIN  = 160,
    parameter int              SCH_WIN  = 576
) (
    input logic               clock,
    input logic               reset,
    mac_slot_sched_n_if.slave bus
);
    localparam int SEL_W = (N_SLOTS > 1) ? $clog2(N_SLOTS) : 1;
    localparam int CNT_W = 10;
    localparam int DL_W  = LEN_W + 3;
    localparam int HB_W  = 1 + ADDR_W + SIZE_W;
    localparam int BC_W  = $clog2(HB_W + 1);
    localparam int DIV_W = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;

    localparam logic [DIV_W-1:0] DIV_LAST   = DIV_W'(CLK_DIV - 1);
    localparam logic [SEL_W-1:0] SLOT_LAST  = SEL_W'(N_SLOTS - 1);
    localparam logic [CNT_W-1:0] CNT_MAX    = '1;
    localparam logic [CNT_W-1:0] BCN_SLOT_C = CNT_W'(BCN_SLOT);
    localparam logic [CNT_W-1:0] BCN_WIN_C  = CNT_W'(BCN_WIN);
    localparam logic [CNT_W-1:0] SCH_WIN_C  = CNT_W'(SCH_WIN);
    localparam logic [BC_W-1:0]  HLEN_BCN   = BC_W'(HB_W);
    localparam logic [BC_W-1:0]  HLEN_SCH   = BC_W'(1 + ADDR_W);

    typedef enum logic [3:0] {
        S_AWAIT_BCN,
        S_SCAN,
        S_PICK,
        S_WAIT,
        S_TX,
        S_GUARD,
        S_AWAIT_SCH,
        S_CALC,
        S_AWAIT_HB
    } state_t;

    state_t              state;
    logic [DIV_W-1:0]    div;
    logic [1:0]          memo;
    logic                is_sch;      // current window belongs to a scheme command
    logic [N_SLOTS-1:0]  flag_q;
    logic [3:0]          rd;
    logic [SIZE_W-1:0]   size_q;
    logic [SEL_W-1:0]    ptr;         // slot walker shared by SCAN, PICK and CALC
    logic [SEL_W:0]      free_cnt;
    logic [CNT_W-1:0]    counter;     // window counter, zeroed on WAIT entry
    logic [CNT_W-1:0]    start_q;     // TX start offset inside the window
    logic [DL_W-1:0]     dlen;
    logic [DL_W-1:0]     cursor;
    logic [SIZE_W-1:0]   data_sent;
    logic [HB_W-1:0]     sh;          // header shift register, MSB goes out first
    logic [BC_W-1:0]     bcnt;

    logic                sending_q;
    logic                head_q;
    logic                datacmd_q;
    logic                working_q;
    logic                no_slot_q;
    logic [SEL_W-1:0]    slot_q;

    // ---------------------------------------------------------------- helpers
    logic                tick;
    logic                accept;
    logic [SEL_W:0]      free_total;
    logic [LEN_W-1:0]    len_k;
    logic [15:0]         sum_ext;
    logic [CNT_W-1:0]    sum_sat;
    logic [CNT_W-1:0]    win;
    logic                win_hit;
    logic [CNT_W-1:0]    cnt_inc;
    logic [BC_W-1:0]     hlen;
    logic [SEL_W-1:0]    ptr_next;
    state_t              exit_state;
    logic                unused_rand;

    assign tick       = (div == DIV_LAST);
    assign accept     = (bus.ord != memo);
    // SCAN decides on the last slot in the same tick, so fold that slot in here.
    assign free_total = free_cnt + {{SEL_W{1'b0}}, ~flag_q[ptr]};
    assign len_k      = bus.cur_scheme[int'(ptr)*LEN_W +: LEN_W];
    assign sum_ext    = {6'd0, start_q} + {{(13-LEN_W){1'b0}}, len_k, 3'b000};
    // A saturated offset exceeds the scheme window, so such a slot never transmits.
    assign sum_sat    = (sum_ext > 16'd1023) ? CNT_MAX : sum_ext[CNT_W-1:0];
    assign win        = is_sch ? SCH_WIN_C : BCN_WIN_C;
    assign win_hit    = (counter >= win);
    assign cnt_inc    = (counter == CNT_MAX) ? counter : counter + 1'b1;
    assign hlen       = is_sch ? HLEN_SCH : HLEN_BCN;
    assign ptr_next   = (ptr == SLOT_LAST) ? '0 : ptr + 1'b1;
    assign exit_state = is_sch ? S_AWAIT_HB : S_AWAIT_SCH;
    // Only rand[3:0] seeds the pick; the rest of the word is deliberately ignored.
    assign unused_rand = ^bus.cur_rand;

    assign bus.sending  = sending_q;
    assign bus.head     = head_q;
    assign bus.datacmd  = datacmd_q;
    assign bus.working  = working_q;
    assign bus.no_slot  = no_slot_q;
    assign bus.slot_sel = slot_q;

    // ---------------------------------------------------------------- FSM
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            state     <= S_AWAIT_BCN;
            div       <= '0;
            memo      <= '0;
            is_sch    <= 1'b0;
            flag_q    <= '0;
            rd        <= '0;
            size_q    <= '0;
            ptr       <= '0;
            free_cnt  <= '0;
            counter   <= '0;
            start_q   <= '0;
            dlen      <= '0;
            cursor    <= '0;
            data_sent <= '0;
            sh        <= '0;
            bcnt      <= '0;
            sending_q <= 1'b0;
            head_q    <= 1'b0;
            datacmd_q <= 1'b0;
            working_q <= 1'b0;
            no_slot_q <= 1'b0;
            slot_q    <= '0;
        end else begin
            div <= tick ? '0 : div + 1'b1;
            if (tick) begin
                case (state)
                    S_AWAIT_BCN: begin
                        if (accept) begin
                            memo <= bus.ord;
                            if (bus.ctg == 2'b01) begin
                                working_q <= 1'b1;
                                no_slot_q <= 1'b0;
                                flag_q    <= bus.cur_flag;
                                rd        <= bus.cur_rand[3:0];
                                size_q    <= bus.data_size_in;
                                is_sch    <= 1'b0;
                                counter   <= '0;
                                ptr       <= '0;
                                free_cnt  <= '0;
                                state     <= S_SCAN;
                            end
                        end
                    end

                    S_SCAN: begin
                        free_cnt <= free_total;
                        ptr      <= ptr_next;
                        if (ptr == SLOT_LAST) begin
                            if (free_total == '0) begin
                                no_slot_q <= 1'b1;
                                working_q <= 1'b0;
                                state     <= S_AWAIT_BCN;
                            end else begin
                                state <= S_PICK;
                            end
                        end
                    end

                    // Walk free slots cyclically; rd counts down once per free slot passed.
                    S_PICK: begin
                        ptr <= ptr_next;
                        if (!flag_q[ptr]) begin
                            if (rd == 4'd0) begin
                                slot_q  <= ptr;
                                start_q <= CNT_W'(ptr) * BCN_SLOT_C;
                                counter <= '0;
                                sh      <= {1'b0, MAC_ADDR, size_q};
                                state   <= S_WAIT;
                            end else begin
                                rd <= rd - 1'b1;
                            end
                        end
                    end

                    // The first header bit goes out on the tick that finds counter==start_q.
                    S_WAIT: begin
                        if (win_hit) begin
                            working_q <= 1'b0;
                            state     <= exit_state;
                        end else begin
                            counter <= cnt_inc;
                            if (counter == start_q) begin
                                head_q    <= sh[HB_W-1];
                                sh        <= sh << 1;
                                bcnt      <= BC_W'(1);
                                sending_q <= 1'b1;
                                datacmd_q <= 1'b0;
                                state     <= S_TX;
                            end
                        end
                    end

                    S_TX: begin
                        counter <= cnt_inc;
                        if (bcnt < hlen) begin
                            head_q <= sh[HB_W-1];
                            sh     <= sh << 1;
                            bcnt   <= bcnt + 1'b1;
                        end else if (is_sch && (cursor < dlen)) begin
                            // Data phase: strobe while payload remains, idle filler after.
                            cursor    <= cursor + 1'b1;
                            datacmd_q <= 1'b1;
                            if (data_sent < size_q) begin
                                sending_q <= 1'b1;
                                data_sent <= data_sent + 1'b1;
                            end else begin
                                sending_q <= 1'b0;
                            end
                        end else begin
                            sending_q <= 1'b0;
                            datacmd_q <= 1'b0;
                            // TX overran the window: leave now instead of guarding.
                            if (win_hit) begin
                                working_q <= 1'b0;
                                state     <= exit_state;
                            end else begin
                                state <= S_GUARD;
                            end
                        end
                    end

                    S_GUARD: begin
                        if (win_hit) begin
                            working_q <= 1'b0;
                            state     <= exit_state;
                        end else begin
                            counter <= cnt_inc;
                        end
                    end

                    S_AWAIT_SCH: begin
                        if (accept) begin
                            memo <= bus.ord;
                            if (bus.ctg == 2'b10) begin
                                working_q <= 1'b1;
                                is_sch    <= 1'b1;
                                ptr       <= '0;
                                start_q   <= '0;
                                dlen      <= '0;
                                cursor    <= '0;
                                state     <= S_CALC;
                            end
                        end
                    end

                    // One slot per tick: accumulate lengths before our slot, grab our own.
                    S_CALC: begin
                        ptr <= ptr_next;
                        if (ptr < slot_q) begin
                            start_q <= sum_sat;
                        end
                        if (ptr == slot_q) begin
                            dlen <= {len_k, 3'b000};
                        end
                        if (ptr == SLOT_LAST) begin
                            counter <= '0;
                            sh      <= {1'b1, MAC_ADDR, {SIZE_W{1'b0}}};
                            state   <= S_WAIT;
                        end
                    end

                    // Heartbeat has no window of its own, so working stays low here.
                    S_AWAIT_HB: begin
                        if (accept) begin
                            memo <= bus.ord;
                            if (bus.ctg == 2'b11) begin
                                if (data_sent == size_q) begin
                                    data_sent <= '0;
                                end
                                state <= S_AWAIT_BCN;
                            end
                        end
                    end

                    default: state <= S_AWAIT_BCN;
                endcase
            end
        end
    end
endmodule

// File: tb/tb_mac_slot_sched_n.sv
// Purpose : self-checking bench for mac_slot_sched_n with a fast MAC tick.
// Latency : checks sample #1 after each tick edge (CLK_DIV clocks per step).
// Backpressure: n/a; commands are driven as ord/ctg level changes.
module tb_mac_slot_sched_n;
    localparam int N_SLOTS = 8;
    localparam int LEN_W   = 6;
    localparam int ADDR_W  = 3;
    localparam int SIZE_W  = 16;
    localparam int RAND_W  = 24;
    localparam int CLK_DIV = 4;

    logic clock = 1'b0;
    logic reset = 1'b0;
    always #5 clock = ~clock;

    mac_slot_sched_n_if #(
        .N_SLOTS(N_SLOTS), .LEN_W(LEN_W), .RAND_W(RAND_W), .SIZE_W(SIZE_W)
    ) bus ();

    mac_slot_sched_n #(
        .N_SLOTS(N_SLOTS), .LEN_W(LEN_W), .ADDR_W(ADDR_W), .MAC_ADDR(3'b101),
        .SIZE_W(SIZE_W), .RAND_W(RAND_W), .CLK_DIV(CLK_DIV),
        .BCN_SLOT(20), .BCN_WIN(160), .SCH_WIN(576)
    ) dut (
        .clock(clock),
        .reset(reset),
        .bus  (bus)
    );

    int checks = 0;
    int errors = 0;

    typedef struct {
        logic [7:0]  flag;
        logic [23:0] rnd;
        logic [2:0]  slot;
        logic        nslot;
        logic        work;
    } vec_t;

    vec_t vecs [8];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic step();
        repeat (CLK_DIV) @(posedge clock);
        #1;
    endtask

    function automatic logic [7:0] outs();
        return {bus.sending, bus.head, bus.datacmd, bus.working, bus.no_slot, bus.slot_sel};
    endfunction

    // Leaves the bench just after the first tick edge following reset release.
    task automatic do_reset();
        reset   = 1'b0;
        bus.ord = 2'd0;
        bus.ctg = 2'd0;
        #20;
        @(negedge clock);
        reset = 1'b1;
        step();
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        errors++;
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $fatal(1, "watchdog");
    end

    initial begin
        int n;
        logic snd;
        logic dc;
        logic sall;
        logic [19:0] got;
        int pulses;
        int idle;

        vecs[0] = '{flag: 8'hFF, rnd: 24'h000005, slot: 3'd0, nslot: 1'b1, work: 1'b0};
        vecs[1] = '{flag: 8'hF6, rnd: 24'h000003, slot: 3'd3, nslot: 1'b0, work: 1'b1};
        vecs[2] = '{flag: 8'h00, rnd: 24'h000005, slot: 3'd5, nslot: 1'b0, work: 1'b1};
        vecs[3] = '{flag: 8'h00, rnd: 24'h000000, slot: 3'd0, nslot: 1'b0, work: 1'b1};
        vecs[4] = '{flag: 8'h7F, rnd: 24'h000002, slot: 3'd7, nslot: 1'b0, work: 1'b1};
        vecs[5] = '{flag: 8'hAA, rnd: 24'h000009, slot: 3'd2, nslot: 1'b0, work: 1'b1};
        vecs[6] = '{flag: 8'h55, rnd: 24'h000004, slot: 3'd1, nslot: 1'b0, work: 1'b1};
        vecs[7] = '{flag: 8'h00, rnd: 24'hABCDE3, slot: 3'd3, nslot: 1'b0, work: 1'b1};

        bus.ord          = 2'd0;
        bus.ctg          = 2'd0;
        bus.cur_flag     = '0;
        bus.cur_rand     = '0;
        bus.data_size_in = 16'd10;
        bus.cur_scheme   = '0;
        for (int k = 0; k < N_SLOTS; k++) bus.cur_scheme[k*LEN_W +: LEN_W] = LEN_W'(k + 1);

        #20;
        chk("reset_outputs", 32'(outs()), 32'h0);

        // ---- table: slot selection / no-slot, fresh reset per vector
        for (int v = 0; v < 8; v++) begin
            do_reset();
            bus.cur_flag = vecs[v].flag;
            bus.cur_rand = vecs[v].rnd;
            bus.ord      = 2'd1;
            bus.ctg      = 2'b01;
            repeat (60) step();
            chk($sformatf("vec%0d_slot", v),    32'(bus.slot_sel), 32'(vecs[v].slot));
            chk($sformatf("vec%0d_no_slot", v), 32'(bus.no_slot),  32'(vecs[v].nslot));
            chk($sformatf("vec%0d_working", v), 32'(bus.working),  32'(vecs[v].work));
        end

        // ---- no free slot: flag after 8 ticks, never sends, next beacon accepted
        do_reset();
        bus.cur_flag = 8'hFF;
        bus.ord = 2'd1;
        bus.ctg = 2'b01;
        step();
        snd = bus.sending;
        repeat (7) begin step(); snd |= bus.sending; end
        chk("noslot_tick7", 32'(bus.no_slot), 32'd0);
        step();
        snd |= bus.sending;
        chk("noslot_tick8", 32'(bus.no_slot), 32'd1);
        chk("noslot_working", 32'(bus.working), 32'd0);
        chk("noslot_never_sent", 32'(snd), 32'd0);
        bus.cur_flag = 8'h00;
        bus.cur_rand = 24'h000001;
        bus.ord = 2'd2;
        step();
        chk("rebeacon_no_slot_clr", 32'(bus.no_slot), 32'd0);
        chk("rebeacon_working", 32'(bus.working), 32'd1);
        repeat (10) step();
        chk("rebeacon_slot", 32'(bus.slot_sel), 32'd1);

        // ---- beacon reply timing and header content, slot 3
        do_reset();
        bus.cur_flag = 8'hF6;
        bus.cur_rand = 24'h000003;
        bus.data_size_in = 16'd10;
        bus.ord = 2'd1;
        bus.ctg = 2'b01;
        step();
        n = 0;
        for (int i = 1; i <= 200; i++) begin
            step();
            if (bus.sending) begin n = i; break; end
        end
        chk("bcn_rise_tick", 32'(n), 32'd81);
        chk("bcn_slot", 32'(bus.slot_sel), 32'd3);
        got = '0;
        got[19] = bus.head;
        dc = bus.datacmd;
        sall = bus.sending;
        for (int i = 18; i >= 0; i--) begin
            step();
            got[i] = bus.head;
            dc |= bus.datacmd;
            sall &= bus.sending;
        end
        chk("bcn_header", 32'(got), 32'h5000A);
        chk("bcn_datacmd_low", 32'(dc), 32'd0);
        chk("bcn_sending_held", 32'(sall), 32'd1);
        step();
        chk("bcn_tx_end", 32'(bus.sending), 32'd0);
        repeat (79) step();
        chk("bcn_win_last", 32'(bus.working), 32'd1);
        step();
        chk("bcn_win_exit", 32'(bus.working), 32'd0);

        // ---- beacon on slot 1, ord toggled during PICK, then scheme
        do_reset();
        bus.cur_flag = 8'hFD;
        bus.cur_rand = 24'h000000;
        bus.ord = 2'd1;
        bus.ctg = 2'b01;
        step();
        repeat (8) step();
        bus.ord = 2'd2;
        bus.ctg = 2'b10;
        repeat (2) step();
        chk("sch_slot", 32'(bus.slot_sel), 32'd1);
        repeat (161) step();
        chk("sch_pending_ignored", 32'(bus.working), 32'd0);
        step();
        chk("sch_accepted", 32'(bus.working), 32'd1);
        n = 0;
        for (int i = 1; i <= 200; i++) begin
            step();
            if (bus.sending) begin n = i; break; end
        end
        chk("sch_rise_tick", 32'(n), 32'd17);
        got = '0;
        got[3] = bus.head;
        dc = bus.datacmd;
        for (int i = 2; i >= 0; i--) begin
            step();
            got[i] = bus.head;
            dc |= bus.datacmd;
        end
        chk("sch_header", 32'(got), 32'hD);
        chk("sch_hdr_datacmd_low", 32'(dc), 32'd0);
        pulses = 0;
        idle = 0;
        for (int i = 0; i < 16; i++) begin
            step();
            if (i == 0) chk("sch_first_data", 32'({bus.sending, bus.datacmd}), 32'd3);
            if (bus.sending && bus.datacmd) pulses++;
            if (!bus.sending) idle++;
        end
        chk("sch_data_pulses", 32'(pulses), 32'd10);
        chk("sch_idle_ticks", 32'(idle), 32'd6);
        step();
        chk("sch_tx_end", 32'({bus.sending, bus.datacmd}), 32'd0);
        repeat (547) step();
        chk("sch_win_last", 32'(bus.working), 32'd1);
        step();
        chk("sch_win_exit", 32'(bus.working), 32'd0);

        // ---- heartbeat, ignored non-matching command, payload restarts after heartbeat
        bus.ord = 2'd3;
        bus.ctg = 2'b11;
        step();
        bus.ord = 2'd0;
        bus.ctg = 2'b10;
        step();
        chk("bcn_wrong_ctg_ignored", 32'(bus.working), 32'd0);
        bus.ord = 2'd1;
        bus.ctg = 2'b01;
        step();
        chk("hb_then_beacon", 32'(bus.working), 32'd1);
        bus.ord = 2'd2;
        bus.ctg = 2'b10;
        repeat (192) step();
        chk("resume_hdr_last", 32'({bus.sending, bus.head, bus.datacmd}), 32'h6);
        step();
        chk("resume_data_restart", 32'({bus.sending, bus.datacmd}), 32'd3);

        // ---- async reset mid data phase, then a clean beacon
        reset = 1'b0;
        #1;
        chk("midrun_reset_outputs", 32'(outs()), 32'h0);
        do_reset();
        bus.cur_flag = 8'h00;
        bus.cur_rand = 24'h000002;
        bus.ord = 2'd1;
        bus.ctg = 2'b01;
        repeat (12) step();
        chk("post_reset_slot", 32'(bus.slot_sel), 32'd2);
        chk("post_reset_working", 32'(bus.working), 32'd1);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
